// File: rtl/snoop_bus_controller_if.sv
// Snoop bus message and memory write-back handshake signals for snoop_bus_controller.
interface snoop_bus_controller_if;
  logic       bus_valid;
  logic [2:0] bus_msg;
  logic [4:0] bus_addr;
  logic       bus_ready;
  logic       wb_req;
  logic       wb_ack;

  modport master (
    output bus_valid, bus_msg, bus_addr, wb_ack,
    input  bus_ready, wb_req
  );

  modport slave (
    input  bus_valid, bus_msg, bus_addr, wb_ack,
    output bus_ready, wb_req
  );
endinterface

// File: rtl/snoop_bus_controller.sv
// Single-line snooping cache controller (Invalid/Exclusive/Shared) with write-back handshake.
// Define SNOOP_HIT_COUNT_EN to include the saturating snoop hit counter.
module snoop_bus_controller (
  input  logic                         clock,
  input  logic                         reset,
  snoop_bus_controller_if.slave        bus,
  input  logic                         proc_we,
  input  logic [1:0]                   proc_state,
  input  logic [4:0]                   proc_tag,
  output logic [1:0]                   line_state,
  output logic [4:0]                   line_tag,
  output logic                         abort_access,
  output logic                         protocol_error,
  output logic [7:0]                   hit_count
);

  typedef enum logic [1:0] {IDLE, EVAL, WB} state_t;
  typedef enum logic [1:0] {INVALID = 2'b00, EXCLUSIVE = 2'b01, SHARED = 2'b10} line_t;
  typedef enum logic [2:0] {MSG_RD = 3'b001, MSG_INV = 3'b010, MSG_WR = 3'b011} msg_t;

  state_t     state, next_state;
  logic [2:0] cap_msg;
  logic [4:0] cap_addr;
  logic [1:0] target_q, target_d;
  logic       hit;
  logic       upd_line;
  logic [1:0] new_state;
  logic       set_err;

  assign hit = (cap_addr == line_tag) && (line_state != INVALID);

  always_comb begin
    next_state   = state;
    target_d     = target_q;
    upd_line     = 1'b0;
    new_state    = line_state;
    set_err      = 1'b0;
    abort_access = 1'b0;
    bus.bus_ready = 1'b0;
    bus.wb_req   = 1'b0;
    case (state)
      IDLE: begin
        bus.bus_ready = 1'b1;
        if (bus.bus_valid) next_state = EVAL;
      end
      EVAL: begin
        next_state = IDLE;
        if (hit) begin
          case (cap_msg)
            MSG_RD: begin
              if (line_state == EXCLUSIVE) begin
                next_state   = WB;
                target_d     = SHARED;
                abort_access = 1'b1;
              end
            end
            MSG_INV: begin
              if (line_state == SHARED) begin
                upd_line  = 1'b1;
                new_state = INVALID;
              end else if (line_state == EXCLUSIVE) begin
                set_err = 1'b1;
              end
            end
            MSG_WR: begin
              if (line_state == SHARED) begin
                upd_line  = 1'b1;
                new_state = INVALID;
              end else if (line_state == EXCLUSIVE) begin
                next_state   = WB;
                target_d     = INVALID;
                abort_access = 1'b1;
              end
            end
            default: ;
          endcase
        end
      end
      WB: begin
        bus.wb_req = 1'b1;
        if (bus.wb_ack) begin
          next_state = IDLE;
          upd_line   = 1'b1;
          new_state  = target_q;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // A processor load and a bus capture in the same IDLE cycle both land here,
  // so EVAL compares against the freshly loaded line.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      cap_msg        <= '0;
      cap_addr       <= '0;
      target_q       <= '0;
      line_state     <= '0;
      line_tag       <= '0;
      protocol_error <= 1'b0;
    end else begin
      state    <= next_state;
      target_q <= target_d;
      if (state == IDLE && bus.bus_valid) begin
        cap_msg  <= bus.bus_msg;
        cap_addr <= bus.bus_addr;
      end
      if (state == IDLE && proc_we) begin
        line_state <= proc_state;
        line_tag   <= proc_tag;
      end else if (upd_line) begin
        line_state <= new_state;
      end
      if (set_err) protocol_error <= 1'b1;
    end
  end

`ifdef SNOOP_HIT_COUNT_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hit_count <= '0;
    end else if (state == EVAL && hit && hit_count != 8'hFF) begin
      hit_count <= hit_count + 8'd1;
    end
  end
`else
  assign hit_count = '0;
`endif

endmodule

// File: tb/tb_snoop_bus_controller.sv
// Self-checking bench for snoop_bus_controller: directed scenarios plus randomized traffic
// checked against a transaction-level coherence model.
module tb_snoop_bus_controller;
  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       proc_we = 1'b0;
  logic [1:0] proc_state = '0;
  logic [4:0] proc_tag = '0;
  logic [1:0] line_state;
  logic [4:0] line_tag;
  logic       abort_access;
  logic       protocol_error;
  logic [7:0] hit_count;

  snoop_bus_controller_if bus ();

  snoop_bus_controller dut (
    .clock          (clock),
    .reset          (reset),
    .bus            (bus.slave),
    .proc_we        (proc_we),
    .proc_state     (proc_state),
    .proc_tag       (proc_tag),
    .line_state     (line_state),
    .line_tag       (line_tag),
    .abort_access   (abort_access),
    .protocol_error (protocol_error),
    .hit_count      (hit_count)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model of the line copy, error flag and hit tally.
  logic [1:0] m_state;
  logic [4:0] m_tag;
  bit         m_err;
  int         m_cnt;

  function automatic int exp_count();
`ifdef SNOOP_HIT_COUNT_EN
    return m_cnt;
`else
    return 0;
`endif
  endfunction

  // Outcome of one snoop message from the coherence rules.
  function automatic void predict(input logic [2:0] msg, input logic [4:0] addr,
                                  output bit hit, output bit to_wb,
                                  output logic [1:0] fin, output bit err);
    hit   = (addr == m_tag) && (m_state != 2'b00);
    to_wb = 1'b0;
    err   = 1'b0;
    fin   = m_state;
    if (hit && msg inside {3'd1, 3'd2, 3'd3}) begin
      if (m_state == 2'b10) begin
        fin = (msg == 3'd1) ? 2'b10 : 2'b00;
      end else if (m_state == 2'b01) begin
        if (msg == 3'd2) err = 1'b1;
        else begin
          to_wb = 1'b1;
          fin   = (msg == 3'd1) ? 2'b10 : 2'b00;
        end
      end
    end
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // One bus transaction, starting and ending just after a clock edge with the DUT in IDLE.
  task automatic do_txn(input string name, input logic [2:0] msg, input logic [4:0] addr,
                        input bit load, input logic [1:0] ls, input logic [4:0] lt,
                        input int ackdly);
    bit hit, to_wb, err;
    logic [1:0] fin;
    n_cmp++;
    if (bus.bus_ready !== 1'b1) begin
      n_bad++; $display("FAIL %s ready_before got %b want 1", name, bus.bus_ready);
    end
    if (load) begin
      proc_we = 1'b1; proc_state = ls; proc_tag = lt;
      m_state = ls; m_tag = lt;
    end
    bus.bus_valid = 1'b1; bus.bus_msg = msg; bus.bus_addr = addr;
    predict(msg, addr, hit, to_wb, fin, err);
    tick();
    bus.bus_valid = 1'b0;
    bus.bus_msg = 3'($urandom); bus.bus_addr = 5'($urandom);
    proc_we = 1'b1; proc_state = 2'($urandom); proc_tag = 5'($urandom);
    bus.wb_ack = to_wb ? (ackdly == 0) : 1'($urandom);
    n_cmp++;
    if (abort_access !== to_wb || bus.bus_ready !== 1'b0) begin
      n_bad++; $display("FAIL %s eval abort/ready got %b/%b want %b/0", name, abort_access, bus.bus_ready, to_wb);
    end
    if (hit && m_cnt < 255) m_cnt++;
    tick();
    if (to_wb) begin
      for (int i = 0; i < ackdly; i++) begin
        n_cmp++;
        if (bus.wb_req !== 1'b1 || abort_access !== 1'b0 || line_state !== m_state) begin
          n_bad++; $display("FAIL %s wb_hold req/abort/line got %b/%b/%0d want 1/0/%0d", name, bus.wb_req, abort_access, line_state, m_state);
        end
        tick();
      end
      bus.wb_ack = 1'b1;
      n_cmp++;
      if (bus.wb_req !== 1'b1) begin
        n_bad++; $display("FAIL %s wb_ack_cycle req got %b want 1", name, bus.wb_req);
      end
      tick();
    end
    proc_we = 1'b0;
    bus.wb_ack = 1'b0;
    m_state = fin;
    m_err = m_err | err;
    n_cmp++;
    if (line_state !== m_state || line_tag !== m_tag || bus.bus_ready !== 1'b1 || bus.wb_req !== 1'b0 ||
        protocol_error !== m_err || int'(hit_count) != exp_count()) begin
      n_bad++;
      $display("FAIL %s end state/tag/ready/wbreq/err/cnt got %0d/%0d/%b/%b/%b/%0d want %0d/%0d/1/0/%b/%0d",
               name, line_state, line_tag, bus.bus_ready, bus.wb_req, protocol_error, hit_count,
               m_state, m_tag, m_err, exp_count());
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    n_cmp++;
    if (line_state !== 2'b00 || line_tag !== 5'd0 || bus.wb_req !== 1'b0 || abort_access !== 1'b0 ||
        protocol_error !== 1'b0 || hit_count !== 8'd0) begin
      n_bad++; $display("FAIL reset_outputs got %0d/%0d/%b/%b/%b/%0d want 0/0/0/0/0/0",
                        line_state, line_tag, bus.wb_req, abort_access, protocol_error, hit_count);
    end
    reset = 1'b0;
    m_state = 2'b00; m_tag = 5'd0; m_err = 1'b0; m_cnt = 0;
    tick();
    n_cmp++;
    if (bus.bus_ready !== 1'b1) begin
      n_bad++; $display("FAIL reset_ready got %b want 1", bus.bus_ready);
    end
  endtask

  task automatic test_shared_read();
    test_reset();
    do_txn("shared_read", 3'd1, 5'd5, 1'b1, 2'b10, 5'd5, 0);
    n_cmp++;
    if (line_state !== 2'b10) begin
      n_bad++; $display("FAIL shared_read line got %0d want 2", line_state);
    end
  endtask

  task automatic test_excl_write_wb();
    test_reset();
    do_txn("excl_write_wb", 3'd3, 5'd3, 1'b1, 2'b01, 5'd3, 3);
    n_cmp++;
    if (line_state !== 2'b00) begin
      n_bad++; $display("FAIL excl_write_wb line got %0d want 0", line_state);
    end
  endtask

  task automatic test_excl_read_ack_high();
    test_reset();
    proc_we = 1'b1; proc_state = 2'b01; proc_tag = 5'd3;
    tick();
    proc_we = 1'b0;
    m_state = 2'b01; m_tag = 5'd3;
    bus.wb_ack = 1'b1;
    bus.bus_valid = 1'b1; bus.bus_msg = 3'd1; bus.bus_addr = 5'd3;
    tick();
    bus.bus_valid = 1'b0;
    tick();
    n_cmp++;
    if (line_state !== 2'b01 || bus.wb_req !== 1'b1) begin
      n_bad++; $display("FAIL ack_high_wb line/req got %0d/%b want 1/1", line_state, bus.wb_req);
    end
    tick();
    n_cmp++;
    if (line_state !== 2'b10 || bus.wb_req !== 1'b0 || bus.bus_ready !== 1'b1) begin
      n_bad++; $display("FAIL ack_high_done line/req/ready got %0d/%b/%b want 2/0/1", line_state, bus.wb_req, bus.bus_ready);
    end
    bus.wb_ack = 1'b0;
    m_state = 2'b10;
    if (m_cnt < 255) m_cnt++;
  endtask

  task automatic test_protocol_error();
    test_reset();
    do_txn("excl_inval", 3'd2, 5'd7, 1'b1, 2'b01, 5'd7, 0);
    n_cmp++;
    if (protocol_error !== 1'b1 || line_state !== 2'b01) begin
      n_bad++; $display("FAIL excl_inval err/line got %b/%0d want 1/1", protocol_error, line_state);
    end
    do_txn("err_sticky_a", 3'd1, 5'd9, 1'b1, 2'b10, 5'd9, 0);
    do_txn("err_sticky_b", 3'd3, 5'd9, 1'b0, 2'b00, 5'd0, 0);
    n_cmp++;
    if (protocol_error !== 1'b1) begin
      n_bad++; $display("FAIL err_sticky got %b want 1", protocol_error);
    end
  endtask

  task automatic test_miss_and_saturation();
    test_reset();
    do_txn("addr_miss", 3'd3, 5'd9, 1'b1, 2'b10, 5'd2, 0);
    for (int i = 0; i < 300; i++) do_txn("sat_hit", 3'd1, 5'd2, 1'b0, 2'b00, 5'd0, 0);
    n_cmp++;
`ifdef SNOOP_HIT_COUNT_EN
    if (hit_count !== 8'd255) begin
      n_bad++; $display("FAIL saturation got %0d want 255", hit_count);
    end
`else
    if (hit_count !== 8'd0) begin
      n_bad++; $display("FAIL saturation got %0d want 0", hit_count);
    end
`endif
  endtask

  task automatic test_reset_mid_wb();
    test_reset();
    proc_we = 1'b1; proc_state = 2'b01; proc_tag = 5'd3;
    bus.bus_valid = 1'b1; bus.bus_msg = 3'd3; bus.bus_addr = 5'd3;
    tick();
    proc_we = 1'b0; bus.bus_valid = 1'b0;
    tick();
    n_cmp++;
    if (bus.wb_req !== 1'b1) begin
      n_bad++; $display("FAIL mid_wb_req got %b want 1", bus.wb_req);
    end
    reset = 1'b1;
    #1;
    n_cmp++;
    if (bus.wb_req !== 1'b0 || line_state !== 2'b00) begin
      n_bad++; $display("FAIL async_reset req/line got %b/%0d want 0/0", bus.wb_req, line_state);
    end
    tick();
    reset = 1'b0;
    m_state = 2'b00; m_tag = 5'd0; m_err = 1'b0; m_cnt = 0;
    tick();
    n_cmp++;
    if (bus.bus_ready !== 1'b1 || bus.wb_req !== 1'b0) begin
      n_bad++; $display("FAIL post_reset ready/req got %b/%b want 1/0", bus.bus_ready, bus.wb_req);
    end
  endtask

  task automatic test_random();
    bit         load;
    logic [1:0] ls;
    logic [4:0] lt, addr;
    logic [2:0] msg;
    test_reset();
    for (int i = 0; i < 80; i++) begin
      load = 1'($urandom);
      ls   = 2'($urandom_range(0, 3));
      lt   = 5'($urandom);
      msg  = 3'($urandom_range(0, 7));
      addr = ($urandom_range(0, 3) != 0) ? (load ? lt : m_tag) : 5'($urandom);
      do_txn("random", msg, addr, load, ls, lt, int'($urandom_range(0, 3)));
    end
  endtask

  initial begin
    bus.bus_valid = 1'b0;
    bus.bus_msg   = '0;
    bus.bus_addr  = '0;
    bus.wb_ack    = 1'b0;
    test_reset();
    test_shared_read();
    test_excl_write_wb();
    test_excl_read_ack_high();
    test_protocol_error();
    test_miss_and_saturation();
    test_reset_mid_wb();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/snoop_bus_controller.md
SNOOP_BUS_CONTROLLER -- requirements
Module: snoop_bus_controller

Interface
REQ-001 SHALL have ports: clock  in  1  single clock, all state on rising edge.
REQ-002 SHALL have ports: reset  in  1  asynchronous, active-high.
REQ-003 SHALL have ports: bus_valid  in  1  bus message present.
REQ-004 SHALL have ports: bus_msg  in  3  001 read miss, 010 invalidate, 011 write miss; others ignored.
REQ-005 SHALL have ports: bus_addr  in  5  block tag of bus message.
REQ-006 SHALL have ports: bus_ready  out  1  high when a message can be accepted.
REQ-007 SHALL have ports: proc_we, proc_state[1:0], proc_tag[4:0]  in  processor-side line load (state 00 Invalid, 01 Exclusive, 10 Shared).
REQ-008 SHALL have ports: line_state  out  2  and line_tag  out  5  current line copy.
REQ-009 SHALL have ports: wb_req  out  1, wb_ack  in  1  write-back handshake to memory.
REQ-010 SHALL have ports: abort_access  out  1, protocol_error  out  1, hit_count  out  8.

Function
REQ-011 SHALL implement FSM IDLE -> EVAL -> (WB ->) IDLE; bus_ready = 1 only in IDLE.
REQ-012 SHALL capture bus_msg/bus_addr when bus_valid && bus_ready; EVAL follows exactly one cycle later.
REQ-013 SHALL, in IDLE only, load line_state/line_tag from proc_state/proc_tag on proc_we; proc_we in other states is ignored.
REQ-014 SHALL, when proc_we and a bus capture occur in the same IDLE cycle, apply the load first so EVAL sees the loaded line.
REQ-015 SHALL define hit = (captured addr == line_tag) && line_state != Invalid, evaluated in EVAL.
REQ-016 SHALL on miss, or unrecognised bus_msg (000, 1xx), change nothing and return to IDLE.
REQ-017 SHALL on hit Shared+read miss stay Shared; Shared+invalidate or write miss -> Invalid; both return to IDLE next cycle.
REQ-018 SHALL on hit Exclusive+read miss go to WB, target Shared; Exclusive+write miss go to WB, target Invalid.
REQ-019 SHALL pulse abort_access for exactly the EVAL cycle on any transition into WB.
REQ-020 SHALL on hit Exclusive+invalidate leave the line unchanged, set sticky protocol_error, return to IDLE.
REQ-021 SHALL hold wb_req high throughout WB; on the cycle wb_ack is sampled high, drop wb_req, write target state, go IDLE.
REQ-022 SHALL tolerate wb_ack high on WB entry (completion after one WB cycle); wb_ack outside WB is ignored.
REQ-023 SHALL count each hit in EVAL into hit_count, saturating at 255.

Reset
REQ-024 SHALL on reset force FSM IDLE, line_state 00, line_tag 0, wb_req 0, abort_access 0, protocol_error 0, hit_count 0.
REQ-025 SHALL on reset during WB drop wb_req immediately without updating the line; pending message is discarded.
REQ-026 SHALL be the only clear for protocol_error.

Configuration
REQ-027 SHALL with SNOOP_HIT_COUNT_EN defined include the hit counter of REQ-023.
REQ-028 SHALL without SNOOP_HIT_COUNT_EN tie hit_count to 0 and instantiate no counter logic; all other behaviour identical.

Verification
REQ-029 SHALL cover: load Shared tag 5; bus read miss addr 5 -> line stays 10, no wb_req, bus_ready back high 2 cycles after accept.
REQ-030 SHALL cover: load Exclusive tag 3; bus write miss addr 3 -> abort_access 1 cycle, wb_req held until wb_ack asserted 4 cycles later, then line 00.
REQ-031 SHALL cover: load Exclusive tag 3; bus read miss addr 3, wb_ack tied high -> line 10 after exactly 3 cycles from accept.
REQ-032 SHALL cover: load Exclusive tag 7; bus invalidate addr 7 -> protocol_error 1, line stays 01, persists until reset.
REQ-033 SHALL cover: load Shared tag 2; bus write miss addr 9 -> no change; 300 hits -> hit_count 255 (0 without SNOOP_HIT_COUNT_EN).
REQ-034 SHALL cover: reset asserted mid-WB -> wb_req 0 asynchronously, line_state 00, bus_ready 1 after release.
